// File: rtl/dma_bus_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// dma_bus_xfer_ctrl
//
// FPGA-side transaction sequencer for the DSP<->FPGA DMA bus. Picks one of
// four local FIFO channels round-robin (R1, R2 read towards the DSP; W1, W2
// written by the DSP), raises that channel's request line, checks the
// master's strobe/header, then moves a fixed BURST of words using the
// m_rdy/s_rdy handshake. Protocol errors and stalls end the burst with a
// one-cycle abort pulse.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   enable                       allows new grants (never cuts a burst)
//   bus_ad_in/stb/we/m_rdy       registered master signals from the pads
//   bus_ad_out/_en               AD drive data and enable
//   bus_ack/s_rdy/abort          slave handshake outputs
//   bus_req_{r,w}_{1,2}          one-hot request lines
//   rd{1,2}_data/level, _pop     FWFT read FIFO heads, fill levels, pops
//   wr{1,2}_space, _push         write FIFO free space, pushes
//   wr_data                      data towards the write FIFOs
//   busy, xfer_cnt, abort_cnt    status: active, bursts done, aborts
// ---------------------------------------------------------------------------
module dma_bus_xfer_ctrl #(
    parameter int BURST   = 64,
    parameter int LW      = 10,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          enable,
    input  logic [31:0]   bus_ad_in,
    input  logic          bus_stb,
    input  logic          bus_we,
    input  logic          bus_m_rdy,
    output logic [31:0]   bus_ad_out,
    output logic          bus_ad_out_en,
    output logic          bus_ack,
    output logic          bus_s_rdy,
    output logic          bus_abort,
    output logic          bus_req_r_1,
    output logic          bus_req_r_2,
    output logic          bus_req_w_1,
    output logic          bus_req_w_2,
    input  logic [31:0]   rd1_data,
    input  logic [31:0]   rd2_data,
    input  logic [LW-1:0] rd1_level,
    input  logic [LW-1:0] rd2_level,
    output logic          rd1_pop,
    output logic          rd2_pop,
    input  logic [LW-1:0] wr1_space,
    input  logic [LW-1:0] wr2_space,
    output logic          wr1_push,
    output logic          wr2_push,
    output logic [31:0]   wr_data,
    output logic          busy,
    output logic [15:0]   xfer_cnt,
    output logic [7:0]    abort_cnt
);

    localparam int RW = $clog2(BURST + 1);
    localparam int SW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_ACK   = 3'd2,
        S_TURN  = 3'd3,
        S_DATA  = 3'd4,
        S_DONE  = 3'd5,
        S_ABORT = 3'd6
    } state_t;

    // A channel can take a whole burst when its FIFO reports at least BURST words.
    function automatic logic fits_burst(input logic [LW-1:0] avail);
        return (32'(avail) >= 32'(BURST));
    endfunction

    state_t          state_q, state_d;
    logic [1:0]      grant_q, grant_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [RW-1:0]   rem_q, rem_d;
    logic [SW-1:0]   stall_q, stall_d;
    logic [15:0]     xfer_q, xfer_d;
    logic [7:0]      abort_cnt_q, abort_cnt_d;

    // Registered bus controls, decoded from the next state.
    logic [3:0]      req_q, req_d;
    logic            ack_q, ack_d;
    logic            s_rdy_q, s_rdy_d;
    logic            abort_q, abort_d;
    logic            ad_en_q, ad_en_d;
    logic            busy_q, busy_d;
    logic            rd_mode_q, rd_mode_d;
    logic            wr_mode_q, wr_mode_d;

    logic [3:0]      elig_s;
    logic            pick_valid_s;
    logic [1:0]      pick_s;
    logic [1:0]      cand_s;
    logic            hdr_ok_s;
    logic            stall_hit_s;
    logic            in_burst_s;

    assign elig_s = {fits_burst(wr2_space), fits_burst(wr1_space),
                     fits_burst(rd2_level), fits_burst(rd1_level)};

    // Round-robin pick: first eligible channel after the last grant.
    always_comb begin
        pick_valid_s = 1'b0;
        pick_s       = ptr_q;
        cand_s       = ptr_q;
        for (int i = 1; i <= 4; i++) begin
            cand_s = ptr_q + 2'(i);
            if (!pick_valid_s && elig_s[cand_s]) begin
                pick_valid_s = 1'b1;
                pick_s       = cand_s;
            end else begin
                pick_valid_s = pick_valid_s;
            end
        end
    end

    // Header matches when the channel id and direction agree with the grant.
    assign hdr_ok_s    = (bus_ad_in[1:0] == grant_q) && (bus_we == grant_q[1]);
    // The current cycle would be the TIMEOUT-th consecutive idle cycle.
    assign stall_hit_s = (stall_q == SW'(TIMEOUT - 1));

    // Next-state, counters and next value of every registered bus control.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        stall_d     = stall_q;
        xfer_d      = xfer_q;
        abort_cnt_d = abort_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (enable && pick_valid_s) begin
                    grant_d = pick_s;
                    ptr_d   = pick_s;
                    rem_d   = RW'(BURST);
                    stall_d = {SW{1'b0}};
                    state_d = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                // A strobe, good or bad, takes priority over the timeout.
                if (bus_stb) begin
                    stall_d = {SW{1'b0}};
                    state_d = hdr_ok_s ? S_ACK : S_ABORT;
                end else if (stall_hit_s) begin
                    state_d = S_ABORT;
                end else begin
                    stall_d = stall_q + SW'(1);
                end
            end
            S_ACK: begin
                state_d = grant_q[1] ? S_DATA : S_TURN;
            end
            S_TURN: begin
                state_d = S_DATA;
            end
            S_DATA: begin
                if (bus_m_rdy) begin
                    rem_d   = rem_q - RW'(1);
                    stall_d = {SW{1'b0}};
                    if (rem_q == RW'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DATA;
                    end
                end else if (stall_hit_s) begin
                    state_d = S_ABORT;
                end else begin
                    stall_d = stall_q + SW'(1);
                end
            end
            S_DONE: begin
                xfer_d  = xfer_q + 16'd1;
                state_d = S_IDLE;
            end
            S_ABORT: begin
                if (abort_cnt_q != 8'hFF) begin
                    abort_cnt_d = abort_cnt_q + 8'd1;
                end else begin
                    abort_cnt_d = abort_cnt_q;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_burst_s = (state_d == S_REQ) || (state_d == S_ACK) ||
                     (state_d == S_TURN) || (state_d == S_DATA);
        req_d      = in_burst_s ? (4'b0001 << grant_d) : 4'b0000;
        ack_d      = (state_d == S_ACK);
        s_rdy_d    = (state_d == S_DATA);
        abort_d    = (state_d == S_ABORT);
        rd_mode_d  = (state_d == S_DATA) && !grant_d[1];
        wr_mode_d  = (state_d == S_DATA) && grant_d[1];
        // Turnaround cycle already drives AD so the master sees a clean handover.
        ad_en_d    = (state_d == S_TURN) || rd_mode_d;
        busy_d     = (state_d != S_IDLE);
    end

    // State, counters and bus-control registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            grant_q     <= 2'd0;
            ptr_q       <= 2'd3;
            rem_q       <= {RW{1'b0}};
            stall_q     <= {SW{1'b0}};
            xfer_q      <= 16'd0;
            abort_cnt_q <= 8'd0;
            req_q       <= 4'b0000;
            ack_q       <= 1'b0;
            s_rdy_q     <= 1'b0;
            abort_q     <= 1'b0;
            ad_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            rd_mode_q   <= 1'b0;
            wr_mode_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            stall_q     <= stall_d;
            xfer_q      <= xfer_d;
            abort_cnt_q <= abort_cnt_d;
            req_q       <= req_d;
            ack_q       <= ack_d;
            s_rdy_q     <= s_rdy_d;
            abort_q     <= abort_d;
            ad_en_q     <= ad_en_d;
            busy_q      <= busy_d;
            rd_mode_q   <= rd_mode_d;
            wr_mode_q   <= wr_mode_d;
        end
    end

    assign bus_req_r_1   = req_q[0];
    assign bus_req_r_2   = req_q[1];
    assign bus_req_w_1   = req_q[2];
    assign bus_req_w_2   = req_q[3];
    assign bus_ack       = ack_q;
    assign bus_s_rdy     = s_rdy_q;
    assign bus_abort     = abort_q;
    assign bus_ad_out_en = ad_en_q;
    assign busy          = busy_q;
    assign xfer_cnt      = xfer_q;
    assign abort_cnt     = abort_cnt_q;

    // Data path is combinational so a word moves in the same cycle as m_rdy.
    assign bus_ad_out = rd_mode_q ? (grant_q[0] ? rd2_data : rd1_data) : 32'd0;
    assign rd1_pop    = rd_mode_q && bus_m_rdy && !grant_q[0];
    assign rd2_pop    = rd_mode_q && bus_m_rdy && grant_q[0];
    assign wr_data    = wr_mode_q ? bus_ad_in : 32'd0;
    assign wr1_push   = wr_mode_q && bus_m_rdy && !grant_q[0];
    assign wr2_push   = wr_mode_q && bus_m_rdy && grant_q[0];

endmodule

// File: tb/tb_dma_bus_xfer_ctrl.sv
module tb_dma_bus_xfer_ctrl;
    localparam int BURST   = 64;
    localparam int LW      = 10;
    localparam int TIMEOUT = 1024;

    localparam int P_IDLE = 0, P_REQ = 1, P_ACK = 2, P_TURN = 3,
                   P_DATA = 4, P_DONE = 5, P_ABORT = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_i = 1'b1;
    logic          enable = 1'b0;
    logic [31:0]   bus_ad_in = 32'd0;
    logic          bus_stb = 1'b0, bus_we = 1'b0, bus_m_rdy = 1'b0;
    logic [31:0]   bus_ad_out;
    logic          bus_ad_out_en, bus_ack, bus_s_rdy, bus_abort;
    logic          bus_req_r_1, bus_req_r_2, bus_req_w_1, bus_req_w_2;
    logic [31:0]   rd1_data = 32'd0, rd2_data = 32'd0;
    logic [LW-1:0] rd1_level = '0, rd2_level = '0, wr1_space = '0, wr2_space = '0;
    logic          rd1_pop, rd2_pop, wr1_push, wr2_push;
    logic [31:0]   wr_data;
    logic          busy;
    logic [15:0]   xfer_cnt;
    logic [7:0]    abort_cnt;

    dma_bus_xfer_ctrl #(.BURST(BURST), .LW(LW), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_i(rst_i), .enable(enable),
        .bus_ad_in(bus_ad_in), .bus_stb(bus_stb), .bus_we(bus_we), .bus_m_rdy(bus_m_rdy),
        .bus_ad_out(bus_ad_out), .bus_ad_out_en(bus_ad_out_en),
        .bus_ack(bus_ack), .bus_s_rdy(bus_s_rdy), .bus_abort(bus_abort),
        .bus_req_r_1(bus_req_r_1), .bus_req_r_2(bus_req_r_2),
        .bus_req_w_1(bus_req_w_1), .bus_req_w_2(bus_req_w_2),
        .rd1_data(rd1_data), .rd2_data(rd2_data),
        .rd1_level(rd1_level), .rd2_level(rd2_level),
        .rd1_pop(rd1_pop), .rd2_pop(rd2_pop),
        .wr1_space(wr1_space), .wr2_space(wr2_space),
        .wr1_push(wr1_push), .wr2_push(wr2_push),
        .wr_data(wr_data), .busy(busy), .xfer_cnt(xfer_cnt), .abort_cnt(abort_cnt)
    );

    int tests = 0, fails = 0;

    // Behavioural model: transaction phase, grant, words left, idle run length.
    int m_phase = P_IDLE, m_grant = 0, m_ptr = 3, m_left = 0, m_wait = 0;
    int m_words = 0, m_xfers = 0, m_aborts = 0, m_events = 0;

    // Master knobs.
    bit stb_en = 1'b1, force_hdr_en = 1'b0, force_we = 1'b0, rdy_rand = 1'b0;
    logic [1:0] force_hdr = 2'd0;
    int stop_n = 1000, stall_len = 0, stall_drv = 0;

    // Observations of the DUT.
    int n_rd1_pop, n_rd2_pop, n_push, n_abort_pulse, n_ack, n_turn;
    int dut_grants[$];
    logic [3:0] prev_req = 4'b0000;

    function automatic bit eligible(input int c);
        case (c)
            0: return int'(rd1_level) >= BURST;
            1: return int'(rd2_level) >= BURST;
            2: return int'(wr1_space) >= BURST;
            3: return int'(wr2_space) >= BURST;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_step();
        int c;
        if (rst_i) begin
            m_phase = P_IDLE; m_ptr = 3; m_grant = 0; m_left = 0;
            m_wait = 0; m_words = 0; m_xfers = 0; m_aborts = 0;
        end else begin
            case (m_phase)
                P_IDLE: if (enable) begin
                    for (int k = 1; k <= 4; k++) begin
                        c = (m_ptr + k) % 4;
                        if (m_phase == P_IDLE && eligible(c)) begin
                            m_grant = c; m_ptr = c; m_left = BURST;
                            m_wait = 0; m_words = 0; m_phase = P_REQ;
                        end
                    end
                end
                P_REQ: begin
                    if (bus_stb) begin
                        m_wait = 0;
                        if (int'(bus_ad_in[1:0]) == m_grant && bus_we == (m_grant >= 2))
                            m_phase = P_ACK;
                        else
                            m_phase = P_ABORT;
                    end else begin
                        m_wait++;
                        if (m_wait >= TIMEOUT) m_phase = P_ABORT;
                    end
                end
                P_ACK:  m_phase = (m_grant >= 2) ? P_DATA : P_TURN;
                P_TURN: m_phase = P_DATA;
                P_DATA: begin
                    if (bus_m_rdy) begin
                        m_left--; m_words++; m_wait = 0;
                        if (m_left == 0) m_phase = P_DONE;
                    end else begin
                        m_wait++;
                        if (m_wait >= TIMEOUT) m_phase = P_ABORT;
                    end
                end
                P_DONE: begin
                    m_xfers = (m_xfers + 1) % 65536; m_events++; m_phase = P_IDLE;
                end
                P_ABORT: begin
                    if (m_aborts < 255) m_aborts++;
                    m_events++; m_phase = P_IDLE;
                end
                default: m_phase = P_IDLE;
            endcase
        end
    endtask

    task automatic master_drive();
        rd1_data  = $urandom;
        rd2_data  = $urandom;
        bus_ad_in = $urandom;
        bus_we    = 1'($urandom % 2);
        bus_stb   = 1'b0;
        if (m_phase == P_REQ && stb_en && ($urandom % 3 != 0)) begin
            bus_stb = 1'b1;
            bus_ad_in[1:0] = force_hdr_en ? force_hdr : 2'(m_grant);
            bus_we = force_hdr_en ? force_we : (m_grant >= 2);
        end
        if (m_phase == P_DATA && m_words >= stop_n && stall_drv < stall_len) begin
            bus_m_rdy = 1'b0;
            stall_drv++;
        end else begin
            bus_m_rdy = rdy_rand ? ($urandom % 4 != 0) : 1'b1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic compare();
        bit e_bus, e_rd, e_wr;
        logic [3:0] e_req, g_req;
        e_bus = (m_phase == P_REQ) || (m_phase == P_ACK) || (m_phase == P_TURN) || (m_phase == P_DATA);
        e_rd  = (m_phase == P_DATA) && (m_grant < 2);
        e_wr  = (m_phase == P_DATA) && (m_grant >= 2);
        e_req = e_bus ? (4'b0001 << m_grant) : 4'b0000;
        g_req = {bus_req_w_2, bus_req_w_1, bus_req_r_2, bus_req_r_1};
        chk("req", 32'(g_req), 32'(e_req));
        chk("ctl", 32'({bus_ack, bus_s_rdy, bus_abort, bus_ad_out_en, busy}),
            32'({m_phase == P_ACK, m_phase == P_DATA, m_phase == P_ABORT,
                 (m_phase == P_TURN) || e_rd, m_phase != P_IDLE}));
        chk("popush", 32'({rd1_pop, rd2_pop, wr1_push, wr2_push}),
            32'({e_rd && bus_m_rdy && m_grant == 0, e_rd && bus_m_rdy && m_grant == 1,
                 e_wr && bus_m_rdy && m_grant == 2, e_wr && bus_m_rdy && m_grant == 3}));
        chk("ad_out", bus_ad_out, e_rd ? ((m_grant == 0) ? rd1_data : rd2_data) : 32'd0);
        chk("wr_data", wr_data, e_wr ? bus_ad_in : 32'd0);
        chk("xfer_cnt", 32'(xfer_cnt), 32'(m_xfers));
        chk("abort_cnt", 32'(abort_cnt), 32'(m_aborts));
        if (rd1_pop) n_rd1_pop++;
        if (rd2_pop) n_rd2_pop++;
        if (wr1_push || wr2_push) n_push++;
        if (bus_abort) n_abort_pulse++;
        if (bus_ack) n_ack++;
        if (bus_ad_out_en && !bus_s_rdy) n_turn++;
        if (prev_req == 4'b0000 && g_req != 4'b0000) begin
            for (int i = 0; i < 4; i++) if (g_req[i]) dut_grants.push_back(i);
        end
        prev_req = g_req;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        master_drive();
        #1;
        compare();
    endtask

    task automatic clr();
        n_rd1_pop = 0; n_rd2_pop = 0; n_push = 0; n_abort_pulse = 0;
        n_ack = 0; n_turn = 0; dut_grants.delete();
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        stb_en = 1'b1; force_hdr_en = 1'b0; rdy_rand = 1'b0;
        stop_n = 1000; stall_len = 0; stall_drv = 0;
        step(); step();
        rst_i = 1'b0;
        clr();
    endtask

    task automatic run_events(input int n, input int budget, input string nm);
        int target;
        int c;
        target = m_events + n;
        c = 0;
        while (m_events < target && c < budget) begin
            step();
            c++;
        end
        tests++;
        if (m_events < target) begin
            fails++;
            $display("FAIL %s: burst did not finish, got %0d events, expected %0d", nm, m_events, target);
        end
    endtask

    initial begin
        int exp_order[5];
        int c;
        exp_order = '{0, 1, 2, 3, 0};

        // Single R1 read burst with continuous m_rdy.
        enable = 1'b1; rd1_level = 10'd64;
        do_reset();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_xfer", 32'(xfer_cnt), 32'd0);
        step();
        chk("s1_req_r1", 32'(bus_req_r_1), 32'd1);
        run_events(1, 300, "s1");
        rd1_level = 10'd0;
        step(); step();
        chk("s1_pops", 32'(n_rd1_pop), 32'd64);
        chk("s1_acks", 32'(n_ack), 32'd1);
        chk("s1_turns", 32'(n_turn), 32'd1);
        chk("s1_xfer", 32'(xfer_cnt), 32'd1);
        chk("s1_busy", 32'(busy), 32'd0);
        chk("s1_req", 32'({bus_req_r_1, bus_req_r_2, bus_req_w_1, bus_req_w_2}), 32'd0);

        // All four eligible, random m_rdy: round-robin order.
        do_reset();
        rd1_level = 10'($urandom_range(64, 1023)); rd2_level = 10'($urandom_range(64, 1023));
        wr1_space = 10'($urandom_range(64, 1023)); wr2_space = 10'($urandom_range(64, 1023));
        rdy_rand = 1'b1;
        run_events(5, 2000, "s2");
        rd1_level = 10'd0; rd2_level = 10'd0; wr1_space = 10'd0; wr2_space = 10'd0;
        rdy_rand = 1'b0;
        chk("s2_ngrants", 32'(dut_grants.size()), 32'd5);
        for (int i = 0; i < 5; i++) chk("s2_order", 32'(dut_grants[i]), 32'(exp_order[i]));
        chk("s2_pushes", 32'(n_push), 32'd128);
        chk("s2_xfer", 32'(xfer_cnt), 32'd5);

        // W2 with header 3 but we=0: protocol abort.
        do_reset();
        wr2_space = 10'd64;
        force_hdr_en = 1'b1; force_hdr = 2'd3; force_we = 1'b0;
        run_events(1, 200, "s3");
        force_hdr_en = 1'b0; wr2_space = 10'd0;
        step();
        chk("s3_grant", 32'(dut_grants[0]), 32'd3);
        chk("s3_abort_cnt", 32'(abort_cnt), 32'd1);
        chk("s3_pulse", 32'(n_abort_pulse), 32'd1);
        chk("s3_push", 32'(n_push), 32'd0);
        chk("s3_busy", 32'(busy), 32'd0);
        // No strobe at all: request timeout.
        wr1_space = 10'd64; stb_en = 1'b0;
        run_events(1, 1200, "s3_to");
        stb_en = 1'b1; wr1_space = 10'd0;
        chk("s3_to_abort_cnt", 32'(abort_cnt), 32'd2);
        chk("s3_to_pulse", 32'(n_abort_pulse), 32'd2);

        // R2 stalls after 10 words for a full TIMEOUT: abort, then W1 next.
        do_reset();
        rd2_level = 10'd64; wr1_space = 10'd64;
        stop_n = 10; stall_len = TIMEOUT; stall_drv = 0;
        run_events(1, 3000, "s4a");
        chk("s4_pops", 32'(n_rd2_pop), 32'd10);
        chk("s4_abort_cnt", 32'(abort_cnt), 32'd1);
        stop_n = 1000;
        run_events(1, 500, "s4b");
        wr1_space = 10'd0;
        chk("s4_first", 32'(dut_grants[0]), 32'd1);
        chk("s4_next_w1", 32'(dut_grants[1]), 32'd2);
        // Same stall but m_rdy returns on the last allowed cycle.
        n_rd2_pop = 0;
        stop_n = 10; stall_len = TIMEOUT - 1; stall_drv = 0;
        run_events(1, 3000, "s4c");
        rd2_level = 10'd0;
        chk("s4c_pops", 32'(n_rd2_pop), 32'd64);
        chk("s4c_abort_cnt", 32'(abort_cnt), 32'd1);
        chk("s4c_xfer", 32'(xfer_cnt), 32'd2);
        chk("s4c_pulse", 32'(n_abort_pulse), 32'd1);

        // Reset in the middle of an R1 burst, R2 also eligible.
        do_reset();
        rd1_level = 10'd64; rd2_level = 10'd64;
        c = 0;
        while (!(m_phase == P_DATA && m_words >= 30) && c < 500) begin step(); c++; end
        chk("s5_words", 32'(m_words), 32'd30);
        rst_i = 1'b1;
        step();
        chk("s5_busy", 32'(busy), 32'd0);
        chk("s5_pop", 32'(rd1_pop), 32'd0);
        chk("s5_req", 32'(bus_req_r_1), 32'd0);
        rst_i = 1'b0;
        run_events(1, 500, "s5");
        rd1_level = 10'd0; rd2_level = 10'd0;
        chk("s5_regrant_r1", 32'(dut_grants[1]), 32'd0);
        chk("s5_pulse", 32'(n_abort_pulse), 32'd0);
        chk("s5_abort_cnt", 32'(abort_cnt), 32'd0);

        // Enable dropped during DATA: burst completes, nothing new starts.
        do_reset();
        rd1_level = 10'd64;
        c = 0;
        while (m_phase != P_DATA && c < 100) begin step(); c++; end
        enable = 1'b0;
        run_events(1, 500, "s6");
        rd1_level = 10'd100;
        repeat (50) step();
        chk("s6_grants", 32'(dut_grants.size()), 32'd1);
        chk("s6_xfer", 32'(xfer_cnt), 32'd1);
        chk("s6_busy", 32'(busy), 32'd0);
        enable = 1'b1;
        run_events(1, 500, "s6b");
        chk("s6_regrant", 32'(dut_grants.size()), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
